// File: rtl/reg_file_stage.sv
// reg_file_stage
//
// Operand-fetch stage that feeds the 8-bit adder. It holds a DEPTH x WIDTH
// register file with one synchronous write-back port and two read ports. The
// read results land in a registered operand pair, and a valid/ready handshake
// on each side lets the consumer stall the stage.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   reset        in   synchronous active-low reset
//   write        in   write-back enable
//   inaddress    in   write-back register address
//   in           in   write-back data (ALU result)
//   rd_valid     in   read request present
//   out1address  in   source register 1 address
//   out2address  in   source register 2 address
//   rd_ready     out  stage can accept a read request this cycle
//   op_valid     out  operand1/operand2 hold a valid pair
//   op_ready     in   consumer takes the operand pair this cycle
//   operand1     out  registered operand 1 (adder data1)
//   operand2     out  registered operand 2 (adder data2)
//
// State | meaning
// ------+------------------------------------------------------------
// EMPTY | no operand pair held; any read request is accepted
// FULL  | operand pair held; reload only when consumer takes the pair

module reg_file_stage #(
    parameter int WIDTH = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 2**AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [AW-1:0]    inaddress,
    input  logic [WIDTH-1:0] in,
    input  logic             rd_valid,
    input  logic [AW-1:0]    out1address,
    input  logic [AW-1:0]    out2address,
    output logic             rd_ready,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] operand1,
    output logic [WIDTH-1:0] operand2
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             accept;

    // Held low during reset so no request is reported as accepted.
    assign rd_ready = reset & ((state == EMPTY) | op_ready);
    assign accept   = rd_valid & rd_ready;

    // Write-to-read forwarding: a same-cycle write to the read address
    // supplies the value the register will hold after this edge.
    always_comb begin
        src1 = regs[out1address];
        if (write && (inaddress == out1address)) begin
            src1 = in;
        end
        src2 = regs[out2address];
        if (write && (inaddress == out2address)) begin
            src2 = in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[inaddress] <= in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (op_ready && !accept) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        op_valid = (state == FULL);
    end

    // Operands only change on accept, so a stalled pair stays bit-stable and
    // later writes to its source registers never leak into it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            operand1 <= '0;
            operand2 <= '0;
        end else if (accept) begin
            operand1 <= src1;
            operand2 <= src2;
        end
    end

endmodule

// File: tb/tb_reg_file_stage.sv
`timescale 1ns/100ps

module tb_reg_file_stage;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             reset;
    logic             write;
    logic [AW-1:0]    inaddress;
    logic [WIDTH-1:0] in;
    logic             rd_valid;
    logic [AW-1:0]    out1address;
    logic [AW-1:0]    out2address;
    logic             rd_ready;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_stage #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .inaddress   (inaddress),
        .in          (in),
        .rd_valid    (rd_valid),
        .out1address (out1address),
        .out2address (out2address),
        .rd_ready    (rd_ready),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .operand1    (operand1),
        .operand2    (operand2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream adder with its #2 combinational delay.
    always_comb sum = operand1 + operand2;

    typedef struct {
        logic       w;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       rv;
        logic [2:0] a1;
        logic [2:0] a2;
        logic       opr;
        logic       e_rdy;
        logic       e_val;
        logic [7:0] e_op1;
        logic [7:0] e_op2;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                                input logic rv, input logic [2:0] a1, input logic [2:0] a2,
                                input logic opr, input logic e_rdy, input logic e_val,
                                input logic [7:0] e_op1, input logic [7:0] e_op2);
        vec_t v;
        v.w = w; v.wa = wa; v.wd = wd; v.rv = rv; v.a1 = a1; v.a2 = a2; v.opr = opr;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_op1 = e_op1; v.e_op2 = e_op2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                         input logic rv, input logic [2:0] a1, input logic [2:0] a2,
                         input logic opr);
        write = w; inaddress = wa; in = wd;
        rd_valid = rv; out1address = a1; out2address = a2; op_ready = opr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_rd_ready", rd_ready, 0);
        check("reset_op_valid", op_valid, 0);
        check("reset_operand1", operand1, 8'h00);
        check("reset_operand2", operand2, 8'h00);
        reset = 1'b1;

        // Table: basic fetch, bypass, stall/drain, preload, back-to-back.
        tbl[0] = mk(1, 1, 8'h12, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00);
        tbl[1] = mk(1, 2, 8'h34, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00);
        tbl[2] = mk(0, 0, 8'h00, 1, 1, 2, 1, 1, 1, 8'h12, 8'h34);
        tbl[3] = mk(1, 5, 8'h01, 0, 0, 0, 1, 1, 0, 8'h12, 8'h34);
        tbl[4] = mk(1, 5, 8'h77, 1, 5, 5, 1, 1, 1, 8'h77, 8'h77);
        tbl[5] = mk(1, 3, 8'h99, 1, 3, 5, 1, 1, 1, 8'h99, 8'h77);
        tbl[6] = mk(1, 4, 8'hAB, 1, 5, 3, 1, 1, 1, 8'h77, 8'h99);
        tbl[7] = mk(0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'h77, 8'h99);
        tbl[8] = mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h77, 8'h99);
        for (int i = 0; i < 8; i++) begin
            tbl[9 + i]  = mk(1, 3'(i), 8'(i * 17), 0, 0, 0, 1, 1, 0, 8'h77, 8'h99);
            tbl[17 + i] = mk(0, 0, 8'h00, 1, 3'(i), 3'(7 - i), 1, 1, 1,
                             8'(i * 17), 8'((7 - i) * 17));
        end

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].a1, tbl[i].a2, tbl[i].opr);
            #1;
            check($sformatf("vec%0d_rd_ready", i), rd_ready, tbl[i].e_rdy);
            tick();
            check($sformatf("vec%0d_op_valid", i), op_valid, tbl[i].e_val);
            check($sformatf("vec%0d_operand1", i), operand1, tbl[i].e_op1);
            check($sformatf("vec%0d_operand2", i), operand2, tbl[i].e_op2);
            if (i == 2) begin
                #2;
                check("add_sum", sum, 8'h46);
            end
        end

        // Stall: fetch (1,2), hold for 3 cycles while overwriting r1.
        drive(1, 1, 8'h12, 0, 0, 0, 1); tick();
        drive(1, 2, 8'h34, 0, 0, 0, 1); tick();
        drive(0, 0, 8'h00, 1, 1, 2, 1); tick();
        check("stall_fetch_op1", operand1, 8'h12);
        check("stall_fetch_op2", operand2, 8'h34);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 8'hFF, 1, 1, 1, 0);
            #1;
            check($sformatf("stall%0d_rd_ready", k), rd_ready, 0);
            tick();
            check($sformatf("stall%0d_op_valid", k), op_valid, 1);
            check($sformatf("stall%0d_operand1", k), operand1, 8'h12);
            check($sformatf("stall%0d_operand2", k), operand2, 8'h34);
        end
        drive(0, 0, 8'h00, 0, 0, 0, 1);
        #1;
        check("drain_rd_ready", rd_ready, 1);
        tick();
        check("drain_op_valid", op_valid, 0);
        drive(0, 0, 8'h00, 1, 1, 2, 1); tick();
        check("after_stall_r1", operand1, 8'hFF);
        check("after_stall_r2", operand2, 8'h34);

        // Reset mid-stall, with a write in the reset cycle that must be dropped.
        drive(1, 3, 8'h5A, 1, 0, 0, 0); tick();
        check("prestall_op_valid", op_valid, 1);
        drive(1, 3, 8'h77, 1, 3, 3, 0);
        reset = 1'b0;
        #1;
        check("rst_stall_rd_ready", rd_ready, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 0, 0);
        #1;
        check("rst_stall_op_valid", op_valid, 0);
        check("rst_stall_operand1", operand1, 8'h00);
        check("rst_stall_operand2", operand2, 8'h00);
        check("rst_release_rd_ready", rd_ready, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 8'h00, 1, 3'(2 * k), 3'(2 * k + 1), 1);
            tick();
            check($sformatf("cleared_r%0d", 2 * k), operand1, 8'h00);
            check($sformatf("cleared_r%0d", 2 * k + 1), operand2, 8'h00);
            check($sformatf("cleared_valid%0d", k), op_valid, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_stage.md
# reg_file_stage

Operand-fetch stage directly upstream of the 8-bit ADD unit. It holds an 8×8-bit register file with one synchronous write port (ALU write-back) and two read ports. Read results are captured into a registered operand pair (OPERAND1/OPERAND2) that drives the adder's DATA1/DATA2 inputs. A valid/ready handshake on both sides lets the consumer stall the stage without losing operands.

## Interface
- WIDTH, 8, data width of every register and operand
- DEPTH, 8, number of registers
- AW, 3, register address width (DEPTH = 2**AW)

- CLK  in  1  clock, all state changes on rising edge
- RESET  in  1  synchronous, active-low reset
- WRITE  in  1  write-back enable
- INADDRESS  in  AW  write-back register address
- IN  in  WIDTH  write-back data (ALU RESULT)
- RD_VALID  in  1  read request present
- OUT1ADDRESS  in  AW  source register 1 address
- OUT2ADDRESS  in  AW  source register 2 address
- RD_READY  out  1  stage can accept a read request this cycle
- OP_VALID  out  1  OPERAND1/OPERAND2 hold a valid pair
- OP_READY  in  1  consumer takes the operand pair this cycle
- OPERAND1  out  WIDTH  registered operand 1 (to ADD DATA1)
- OPERAND2  out  WIDTH  registered operand 2 (to ADD DATA2)

## Operation
- Reset: sampled on the rising edge with RESET=0. All DEPTH registers clear to 0x00. OP_VALID=0, OPERAND1=OPERAND2=0x00. Reset overrides any write or read request in the same cycle.
- Write: on the rising edge with RESET=1 and WRITE=1, reg[INADDRESS] <= IN. Writes are independent of the read handshake and stalls.
- Accept: a read is accepted on the edge where RD_VALID=1 and RD_READY=1.
- RD_READY = !OP_VALID | OP_READY (combinational). RD_READY=0 while RESET=0.
- On accept, OPERAND1 <= source value of OUT1ADDRESS and OPERAND2 <= source value of OUT2ADDRESS.
- Source value and bypass: if WRITE=1 and INADDRESS equals the read address in the same cycle, the source value is IN (the write is forwarded). Otherwise it is the stored register value. The forward applies independently per port; both ports may hit the same address.
- Two states, tracked by OP_VALID:
  - EMPTY (OP_VALID=0): accept goes to FULL; no accept stays EMPTY.
  - FULL (OP_VALID=1):
    - OP_READY=1 with accept: reload operands, stay FULL.
    - OP_READY=1 without accept: go to EMPTY. OPERANDs keep their last value; they are don't-care to the consumer.
    - OP_READY=0: hold. OPERAND1/OPERAND2 stay bit-stable, RD_READY=0.
- Held operands are never refreshed by later writes to their source registers. The captured value is the value at accept.
- Address and width arithmetic: addresses are unsigned and AW bits wide, with no wrap beyond DEPTH-1. Data passes through unmodified, with no sign or width change.

## Timing
- Latency: read accepted on edge N -> OP_VALID=1 and operands valid after edge N, usable by the consumer in cycle N+1.
- Throughput: one pair per cycle when OP_READY is held at 1.
- Write-to-read: a write on edge N is visible to a normal read accepted on edge N+1. The same-cycle case is covered by the bypass.
- Delays: registered outputs and register-file updates settle #1 after CLK; the combinational RD_READY path settles #1 after its inputs. Timescale is 1ns/100ps, matching the ADD unit's #2 combinational delay.
- Reset mid-stall (FULL, OP_READY=0): the next edge with RESET=0 drops OP_VALID and clears operands and registers. The pending pair is discarded.
- Simultaneous write and accept on different addresses: both take effect on the same edge; the read returns the old value of its own address.

## Test plan
- Reset: write 0x5A to r3, then hold RESET=0 for one edge with WRITE=1 -> r3 reads 0x00 after release, OP_VALID=0, operands 0x00.
- Basic fetch: write r1=0x12, r2=0x34; accept a read of (1,2) with OP_READY=1 -> next cycle OP_VALID=1, OPERAND1=0x12, OPERAND2=0x34, and the ADD output is 0x46 after #2.
- Bypass: write r5=0x77 and read (5,5) on the same edge while r5 previously held 0x01 -> OPERAND1=OPERAND2=0x77.
- Stall: fetch (1,2), hold OP_READY=0 for 3 cycles while writing r1=0xFF -> RD_READY=0 and OPERAND1 stays 0x12 throughout. Raising OP_READY with RD_VALID=0 -> OP_VALID=0 next cycle.
- Back-to-back: 8 consecutive reads (i, 7-i) with OP_READY=1 after preloading ri=i*0x11 -> 8 consecutive valid pairs in order, with no bubbles.
- Reset mid-stall: FULL with OP_READY=0, assert RESET=0 for one edge -> OP_VALID=0, RD_READY=1 after release, all registers 0x00.
